// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register, register-file write-back mux and
//               HALT sequencing FSM (RUN -> DUMP -> HALTED).
//               Optional feature macro: RETIRE_CNT_EN enables the saturating
//               retired-instruction counter; otherwise retire_cnt is 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_read_data,
  input  logic [15:0] alu_result,
  input  logic [15:0] pc_plus2,
  input  logic [1:0]  wb_sel,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic        valid_in,
  input  logic        halt_in,
  input  logic        mem_stall,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_reg,
  output logic        wb_en,
  output logic        createdump,
  output logic        halted,
  output logic        err,
  output logic [15:0] retire_cnt
);

  localparam logic [1:0] SEL_ALU     = 2'b00;
  localparam logic [1:0] SEL_MEM     = 2'b01;
  localparam logic [1:0] SEL_PC      = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DUMP   = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t      state_q;
  logic        createdump_q;
  logic        halted_q;

  logic        valid_q;
  logic        halt_q;
  logic        reg_write_q;
  logic [1:0]  wb_sel_q;
  logic [2:0]  write_reg_q;
  logic [15:0] mem_data_q;
  logic [15:0] alu_q;
  logic [15:0] pc_plus2_q;

  logic        run;

  assign run = (state_q == ST_RUN);

  // MEM/WB register: loads only while running; a stall inserts a bubble
  // by clearing valid and leaving the payload untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      halt_q      <= 1'b0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= 2'b00;
      write_reg_q <= 3'd0;
      mem_data_q  <= 16'h0000;
      alu_q       <= 16'h0000;
      pc_plus2_q  <= 16'h0000;
    end else if (run) begin
      if (mem_stall) begin
        valid_q <= 1'b0;
      end else begin
        valid_q     <= valid_in;
        halt_q      <= halt_in;
        reg_write_q <= reg_write;
        wb_sel_q    <= wb_sel;
        write_reg_q <= write_reg;
        mem_data_q  <= mem_read_data;
        alu_q       <= alu_result;
        pc_plus2_q  <= pc_plus2;
      end
    end
  end

  // HALT sequencing: one DUMP cycle, then HALTED until reset.
  // createdump/halted are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      createdump_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (valid_q && halt_q) begin
            state_q      <= ST_DUMP;
            createdump_q <= 1'b1;
            halted_q     <= 1'b0;
          end else begin
            createdump_q <= 1'b0;
            halted_q     <= 1'b0;
          end
        end
        ST_DUMP: begin
          state_q      <= ST_HALTED;
          createdump_q <= 1'b0;
          halted_q     <= 1'b1;
        end
        ST_HALTED: begin
          createdump_q <= 1'b0;
          halted_q     <= 1'b1;
        end
        default: begin
          state_q      <= ST_RUN;
          createdump_q <= 1'b0;
          halted_q     <= 1'b0;
        end
      endcase
    end
  end

  // Write-back source mux; the illegal encoding yields zero data.
  always_comb begin
    wb_data = 16'h0000;
    case (wb_sel_q)
      SEL_ALU: wb_data = alu_q;
      SEL_MEM: wb_data = mem_data_q;
      SEL_PC:  wb_data = pc_plus2_q;
      default: wb_data = 16'h0000;
    endcase
  end

  // A HALT never writes, and the illegal select both suppresses the write
  // and raises err; nothing writes or faults outside RUN.
  assign wb_en      = valid_q & reg_write_q & ~halt_q & (wb_sel_q != SEL_ILLEGAL) & run;
  assign err        = valid_q & reg_write_q & (wb_sel_q == SEL_ILLEGAL) & run;
  assign wb_reg     = write_reg_q;
  assign createdump = createdump_q;
  assign halted     = halted_q;

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;

  // Count every valid instruction leaving the stage in RUN (HALT included),
  // saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= 16'h0000;
    end else if (run && valid_q && (retire_cnt_q != 16'hFFFF)) begin
      retire_cnt_q <= retire_cnt_q + 16'h0001;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed scoreboard bench for writeback_stage. Each driven
//               cycle queues the hand-computed outputs for the following
//               cycle; an independent monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

`ifdef RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_read_data;
  logic [15:0] alu_result;
  logic [15:0] pc_plus2;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic        valid_in;
  logic        halt_in;
  logic        mem_stall;
  logic [15:0] wb_data;
  logic [2:0]  wb_reg;
  logic        wb_en;
  logic        createdump;
  logic        halted;
  logic        err;
  logic [15:0] retire_cnt;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_data (mem_read_data),
    .alu_result    (alu_result),
    .pc_plus2      (pc_plus2),
    .wb_sel        (wb_sel),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .valid_in      (valid_in),
    .halt_in       (halt_in),
    .mem_stall     (mem_stall),
    .wb_data       (wb_data),
    .wb_reg        (wb_reg),
    .wb_en         (wb_en),
    .createdump    (createdump),
    .halted        (halted),
    .err           (err),
    .retire_cnt    (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wb_en;
    logic        chk_reg;
    logic [2:0]  wb_reg;
    logic        chk_data;
    logic [15:0] wb_data;
    logic        err;
    logic        createdump;
    logic        halted;
    logic [15:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input string fld, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", name, fld, act, want);
    end
  endtask

  // Monitor: outputs are stable 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "wb_en",      {15'd0, wb_en},      {15'd0, e.wb_en});
        chk(e.name, "err",        {15'd0, err},        {15'd0, e.err});
        chk(e.name, "createdump", {15'd0, createdump}, {15'd0, e.createdump});
        chk(e.name, "halted",     {15'd0, halted},     {15'd0, e.halted});
        chk(e.name, "retire_cnt", retire_cnt,          e.rc);
        if (e.chk_reg)  chk(e.name, "wb_reg",  {13'd0, wb_reg}, {13'd0, e.wb_reg});
        if (e.chk_data) chk(e.name, "wb_data", wb_data, e.wb_data);
      end
    end
  end

  function automatic logic [15:0] rcv(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic drive(input logic r, input logic v, input logic h, input logic st,
                       input logic rw, input logic [1:0] sel, input logic [2:0] wr,
                       input logic [15:0] md, input logic [15:0] alu, input logic [15:0] pc);
    @(negedge clk);
    rst = r; valid_in = v; halt_in = h; mem_stall = st; reg_write = rw;
    wb_sel = sel; write_reg = wr; mem_read_data = md; alu_result = alu; pc_plus2 = pc;
  endtask

  // Drive one cycle and queue what the DUT must show after the next edge.
  task automatic step(input string name,
                      input logic r, input logic v, input logic h, input logic st,
                      input logic rw, input logic [1:0] sel, input logic [2:0] wr,
                      input logic [15:0] md, input logic [15:0] alu, input logic [15:0] pc,
                      input logic e_en, input logic e_chk_reg, input logic [2:0] e_reg,
                      input logic e_chk_data, input logic [15:0] e_data,
                      input logic e_err, input logic e_cd, input logic e_halted,
                      input logic [15:0] e_rc);
    exp_t e;
    drive(r, v, h, st, rw, sel, wr, md, alu, pc);
    e.name = name; e.wb_en = e_en; e.chk_reg = e_chk_reg; e.wb_reg = e_reg;
    e.chk_data = e_chk_data; e.wb_data = e_data; e.err = e_err;
    e.createdump = e_cd; e.halted = e_halted; e.rc = e_rc;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    int guard;
    //   name        rst v h st rw sel   wr    md        alu       pc         en  cr reg  cd data      err cd  hlt rc
    step("reset0",   1, 1,0,0, 1,2'b01,3'd3,16'h1111,16'h2222,16'h3333, 0, 0,3'd0, 1,16'h0000, 0, 0, 0, rcv(0));
    step("reset1",   1, 1,1,0, 1,2'b01,3'd3,16'h1111,16'h2222,16'h3333, 0, 0,3'd0, 1,16'h0000, 0, 0, 0, rcv(0));
    step("load",     0, 1,0,0, 1,2'b01,3'd3,16'hBEEF,16'h0000,16'h0000, 1, 1,3'd3, 1,16'hBEEF, 0, 0, 0, rcv(0));
    step("stall",    0, 1,0,1, 1,2'b01,3'd3,16'hBEEF,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 0, rcv(1));
    step("alu",      0, 1,0,0, 1,2'b00,3'd5,16'h0000,16'h1234,16'h0000, 1, 1,3'd5, 1,16'h1234, 0, 0, 0, rcv(1));
    step("illegal",  0, 1,0,0, 1,2'b11,3'd2,16'h5555,16'h6666,16'h7777, 0, 0,3'd0, 1,16'h0000, 1, 0, 0, rcv(2));
    step("no_rw",    0, 1,0,0, 0,2'b01,3'd4,16'hAAAA,16'h0000,16'h0000, 0, 0,3'd0, 1,16'hAAAA, 0, 0, 0, rcv(3));
    step("invalid",  0, 0,0,0, 1,2'b00,3'd6,16'h0000,16'h9999,16'h0000, 0, 0,3'd0, 1,16'h9999, 0, 0, 0, rcv(4));
    step("jal1",     0, 1,0,0, 1,2'b10,3'd1,16'h0000,16'h0000,16'h0010, 1, 1,3'd1, 1,16'h0010, 0, 0, 0, rcv(4));
    step("halt_bub", 0, 1,1,1, 1,2'b00,3'd1,16'h0000,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 0, rcv(5));
    step("halt",     0, 1,1,0, 1,2'b00,3'd2,16'h0000,16'h4444,16'h0000, 0, 0,3'd0, 1,16'h4444, 0, 0, 0, rcv(5));
    step("dump",     0, 1,0,0, 1,2'b01,3'd3,16'hBEEF,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 1, 0, rcv(6));
    step("halted1",  0, 1,0,0, 1,2'b01,3'd3,16'hBEEF,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 1, rcv(6));
    step("halted2",  0, 1,0,0, 1,2'b11,3'd3,16'hBEEF,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 1, rcv(6));
    step("rst_halt", 1, 1,0,0, 1,2'b01,3'd3,16'hBEEF,16'h0000,16'h0000, 0, 0,3'd0, 1,16'h0000, 0, 0, 0, rcv(0));
    step("jal7",     0, 1,0,0, 1,2'b10,3'd7,16'h0000,16'h0000,16'h0042, 1, 1,3'd7, 1,16'h0042, 0, 0, 0, rcv(0));
    step("idle",     0, 0,0,0, 0,2'b00,3'd0,16'h0000,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 0, rcv(1));

    if (CNT_EN) begin
      // Push the counter past its ceiling with unchecked non-writing instructions.
      for (int i = 0; i < 65540; i++) begin
        drive(0, 1, 0, 0, 0, 2'b00, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk);
      end
    end
    step("sat0",     0, 0,0,0, 0,2'b00,3'd0,16'h0000,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 0, CNT_EN ? 16'hFFFF : 16'h0000);
    step("sat1",     0, 0,0,0, 0,2'b00,3'd0,16'h0000,16'h0000,16'h0000, 0, 0,3'd0, 0,16'h0000, 0, 0, 0, CNT_EN ? 16'hFFFF : 16'h0000);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
